ps2_mouse_init_ctrl: RTL and testbench

- Sequences the PS/2 mouse bring-up over the existing host transmitter and mouse receiver.
- Issues Reset (0xFF) and checks the ACK, self-test (BAT) and ID responses. Then issues Enable Data Reporting (0xF4) and checks its ACK.
- Once initialised, asserts stream_en so the packet assembler accepts movement bytes.
- Replaces the manual push-button transmit trigger. Sits between the button/host logic and the tx/rx/packet blocks.

---
 rtl/ps2_pkg.sv | 55 +++++
 rtl/ps2_timeout_timer.sv | 35 +++
 rtl/ps2_mouse_init_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_ps2_mouse_init_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 mouse bring-up logic: command and
// response byte values, the down-counter width and the state encoding of
// the initialisation sequencer.
// No ports (package).

package ps2_pkg;

    // Host-to-mouse command bytes
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;

    // Mouse-to-host response bytes
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_ERR  = 8'hFC;
    localparam logic [7:0] RSP_ID_STD   = 8'h00;

    // Wide enough for a one second BAT wait at 100 MHz
    localparam int TIMER_W = 27;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEND_RST,
        ST_WAIT_TX,
        ST_WAIT_RST_ACK,
        ST_WAIT_BAT,
        ST_WAIT_ID,
        ST_SEND_RATE_CMD,
        ST_WAIT_RATE_CMD_ACK,
        ST_SEND_RATE_VAL,
        ST_WAIT_RATE_VAL_ACK,
        ST_SEND_EN,
        ST_WAIT_EN_ACK,
        ST_STREAM,
        ST_ERROR
    } init_state_t;

    // States guarded by the shared timeout counter
    function automatic logic is_wait_state(init_state_t s);
        return (s == ST_WAIT_TX)           || (s == ST_WAIT_RST_ACK) ||
               (s == ST_WAIT_BAT)          || (s == ST_WAIT_ID)      ||
               (s == ST_WAIT_RATE_CMD_ACK) || (s == ST_WAIT_RATE_VAL_ACK) ||
               (s == ST_WAIT_EN_ACK);
    endfunction

    // States that drive a command byte to the transmitter
    function automatic logic is_send_state(init_state_t s);
        return (s == ST_SEND_RST) || (s == ST_SEND_RATE_CMD) ||
               (s == ST_SEND_RATE_VAL) || (s == ST_SEND_EN);
    endfunction

endpackage

// File: rtl/ps2_timeout_timer.sv
// ps2_timeout_timer
// Loadable down-counter used as the shared timeout for every wait state.
// The count stops at zero; expired stays high until the next load.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset (count cleared)
//   load       in   load load_value this cycle
//   load_value in   WIDTH-bit reload value
//   expired    out  count has reached zero

module ps2_timeout_timer #(
    parameter int WIDTH = 27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/ps2_mouse_init_ctrl.sv
// ps2_mouse_init_ctrl
// Brings up a PS/2 mouse through the existing host transmitter and mouse
// receiver: Reset (FF) with ACK, BAT and ID checks, then Enable Data
// Reporting (F4) with ACK, after which stream_en opens the packet assembler.
// Timeouts, BAT/ID failures and resend requests are retried up to MAX_RETRY
// times before the block parks in ERROR.
// Optional feature macro: PS2_SAMPLE_RATE_EN -- when defined, a Set Sample
// Rate (F3, SAMPLE_RATE) exchange is inserted between the ID check and F4.
// Ports:
//   clk        in   system clock (100 MHz)
//   reset      in   asynchronous active-low reset
//   start      in   one-cycle request to (re)start initialisation
//   tx_start   out  one-cycle transmit request, tx_data valid with it
//   tx_data    out  command byte for the transmitter
//   tx_done    in   one-cycle pulse when the transmitter finished a byte
//   rx_done    in   one-cycle pulse from the mouse receiver
//   rx_data    in   received byte, valid with rx_done
//   stream_en  out  high in STREAM
//   init_busy  out  high while the sequence is in progress
//   init_error out  high in ERROR
//   retry_cnt  out  retries consumed so far

module ps2_mouse_init_ctrl
    import ps2_pkg::*;
#(
    parameter int         ACK_TIMEOUT = 2_000_000,
    parameter int         BAT_TIMEOUT = 100_000_000,
    parameter int         MAX_RETRY   = 3,
    parameter logic [7:0] SAMPLE_RATE = 8'd100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       stream_en,
    output logic       init_busy,
    output logic       init_error,
    output logic [1:0] retry_cnt
);

    localparam logic [TIMER_W-1:0] ACK_LOAD  = TIMER_W'(ACK_TIMEOUT);
    localparam logic [TIMER_W-1:0] BAT_LOAD  = TIMER_W'(BAT_TIMEOUT);
    localparam logic [1:0]         RETRY_MAX = 2'(MAX_RETRY);

    init_state_t        state, next_state;
    init_state_t        ack_state, ack_state_next;
    init_state_t        retry_target;
    logic [1:0]         retry_next;
    logic [7:0]         tx_data_next;
    logic               need_retry;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_expired;

    ps2_timeout_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .expired    (timer_expired)
    );

    // ack_state remembers which response the shared WAIT_TX leads to;
    // tx_data holds the byte of the current SEND state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            ack_state <= ST_IDLE;
            retry_cnt <= 2'd0;
            tx_data   <= 8'h00;
        end else begin
            state     <= next_state;
            ack_state <= ack_state_next;
            retry_cnt <= retry_next;
            tx_data   <= tx_data_next;
        end
    end

    // Next-state logic. Wait states give rx_done/tx_done priority over the
    // timer. A retry goes to retry_target: SEND_RST for a full restart,
    // or the current SEND state for a resend request.
    always_comb begin
        next_state     = state;
        ack_state_next = ack_state;
        retry_next     = retry_cnt;
        tx_data_next   = tx_data;
        need_retry     = 1'b0;
        retry_target   = ST_SEND_RST;
        timer_load     = 1'b0;
        timer_value    = ACK_LOAD;

        case (state)
            ST_IDLE, ST_STREAM, ST_ERROR: begin
                if (start) begin
                    retry_next = 2'd0;
                    next_state = ST_SEND_RST;
                end
            end
            ST_SEND_RST: begin
                next_state     = ST_WAIT_TX;
                ack_state_next = ST_WAIT_RST_ACK;
            end
            ST_SEND_RATE_CMD: begin
                next_state     = ST_WAIT_TX;
                ack_state_next = ST_WAIT_RATE_CMD_ACK;
            end
            ST_SEND_RATE_VAL: begin
                next_state     = ST_WAIT_TX;
                ack_state_next = ST_WAIT_RATE_VAL_ACK;
            end
            ST_SEND_EN: begin
                next_state     = ST_WAIT_TX;
                ack_state_next = ST_WAIT_EN_ACK;
            end
            ST_WAIT_TX: begin
                if (tx_done) begin
                    next_state = ack_state;
                end else if (timer_expired) begin
                    need_retry = 1'b1;
                end
            end
            ST_WAIT_RST_ACK: begin
                if (rx_done) begin
                    if (rx_data == RSP_ACK) begin
                        next_state = ST_WAIT_BAT;
                    end else if (rx_data == RSP_RESEND) begin
                        need_retry = 1'b1;
                    end
                end else if (timer_expired) begin
                    need_retry = 1'b1;
                end
            end
            ST_WAIT_BAT: begin
                if (rx_done) begin
                    if (rx_data == RSP_BAT_OK) begin
                        next_state = ST_WAIT_ID;
                    end else if (rx_data == RSP_BAT_ERR) begin
                        need_retry = 1'b1;
                    end
                end else if (timer_expired) begin
                    need_retry = 1'b1;
                end
            end
            ST_WAIT_ID: begin
                // Unlike the other waits, any unexpected ID forces a retry.
                if (rx_done) begin
                    if (rx_data == RSP_ID_STD) begin
`ifdef PS2_SAMPLE_RATE_EN
                        next_state = ST_SEND_RATE_CMD;
`else
                        next_state = ST_SEND_EN;
`endif
                    end else begin
                        need_retry = 1'b1;
                    end
                end else if (timer_expired) begin
                    need_retry = 1'b1;
                end
            end
            ST_WAIT_RATE_CMD_ACK: begin
                if (rx_done) begin
                    if (rx_data == RSP_ACK) begin
                        next_state = ST_SEND_RATE_VAL;
                    end else if (rx_data == RSP_RESEND) begin
                        need_retry   = 1'b1;
                        retry_target = ST_SEND_RATE_CMD;
                    end
                end else if (timer_expired) begin
                    need_retry = 1'b1;
                end
            end
            ST_WAIT_RATE_VAL_ACK: begin
                if (rx_done) begin
                    if (rx_data == RSP_ACK) begin
                        next_state = ST_SEND_EN;
                    end else if (rx_data == RSP_RESEND) begin
                        need_retry   = 1'b1;
                        retry_target = ST_SEND_RATE_VAL;
                    end
                end else if (timer_expired) begin
                    need_retry = 1'b1;
                end
            end
            ST_WAIT_EN_ACK: begin
                if (rx_done) begin
                    if (rx_data == RSP_ACK) begin
                        next_state = ST_STREAM;
                    end else if (rx_data == RSP_RESEND) begin
                        need_retry   = 1'b1;
                        retry_target = ST_SEND_EN;
                    end
                end else if (timer_expired) begin
                    need_retry = 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        if (need_retry) begin
            if (retry_cnt == RETRY_MAX) begin
                next_state = ST_ERROR;
            end else begin
                retry_next = retry_cnt + 2'd1;
                next_state = retry_target;
            end
        end

        // Latch the command byte so it is valid throughout the SEND cycle.
        case (next_state)
            ST_SEND_RST:      tx_data_next = CMD_RESET;
            ST_SEND_RATE_CMD: tx_data_next = CMD_SET_RATE;
            ST_SEND_RATE_VAL: tx_data_next = SAMPLE_RATE;
            ST_SEND_EN:       tx_data_next = CMD_ENABLE;
            default:          tx_data_next = tx_data;
        endcase

        // Reload the shared timer only when a wait state is newly entered.
        if ((next_state != state) && is_wait_state(next_state)) begin
            timer_load = 1'b1;
        end
        if (next_state == ST_WAIT_BAT) begin
            timer_value = BAT_LOAD;
        end
    end

    assign tx_start   = is_send_state(state);
    assign stream_en  = (state == ST_STREAM);
    assign init_error = (state == ST_ERROR);
    assign init_busy  = (state != ST_IDLE) && (state != ST_STREAM) &&
                        (state != ST_ERROR);

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// tb_ps2_mouse_init_ctrl
// Self-checking bench for ps2_mouse_init_ctrl. A transmitter model answers
// every tx_start with tx_done; a monitor records every transmitted byte in
// a queue. A table of steps (start, expected command, mouse reply, idle
// wait, empty-queue check) drives the main scenarios; reset, start while
// busy and restart from ERROR are written out by hand.

module tb_ps2_mouse_init_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       stream_en;
    logic       init_busy;
    logic       init_error;
    logic [1:0] retry_cnt;

    int tests = 0;
    int fails = 0;

    logic [7:0] txq[$];

    typedef enum {K_START, K_TX, K_RX, K_WAIT, K_QEMPTY} kind_t;

    typedef struct {
        kind_t      kind;
        logic [7:0] data;
        int         cycles;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    ps2_mouse_init_ctrl #(
        .ACK_TIMEOUT (100),
        .BAT_TIMEOUT (300),
        .MAX_RETRY   (3),
        .SAMPLE_RATE (8'd40)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .stream_en  (stream_en),
        .init_busy  (init_busy),
        .init_error (init_error),
        .retry_cnt  (retry_cnt)
    );

    // Record every byte handed to the transmitter
    always @(negedge clk) begin
        if (tx_start) txq.push_back(tx_data);
    end

    // Transmitter model: byte finishes a few cycles after the request
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) begin
                repeat (3) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    // Packs the expected {stream_en, init_busy, init_error, retry_cnt}
    function automatic logic [4:0] st(bit s, bit b, bit e, int r);
        return {s, b, e, 2'(r)};
    endfunction

    function automatic void add(kind_t k, logic [7:0] d, int c, logic [4:0] e);
        vec_t v;
        v.kind   = k;
        v.data   = d;
        v.cycles = c;
        v.exp    = e;
        vecs.push_back(v);
    endfunction

    // ID accepted, plus the sample-rate exchange when that feature is built
    function automatic void addIdOk(int r);
        add(K_RX, 8'h00, 0, st(0, 1, 0, r));
`ifdef PS2_SAMPLE_RATE_EN
        add(K_TX, 8'hF3, 400, st(0, 1, 0, r));
        add(K_RX, 8'hFA, 0,   st(0, 1, 0, r));
        add(K_TX, 8'h28, 400, st(0, 1, 0, r));
        add(K_RX, 8'hFA, 0,   st(0, 1, 0, r));
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [4:0] exp);
        tests++;
        if ({stream_en, init_busy, init_error, retry_cnt} !== exp) begin
            fails++;
            $display("[TB] FAIL %s: stream/busy/err/retry got %b required %b",
                     name, {stream_en, init_busy, init_error, retry_cnt}, exp);
        end
    endtask

    task automatic checkQueueEmpty(input string name);
        tests++;
        if (txq.size() != 0) begin
            fails++;
            $display("[TB] FAIL %s: %0d unexpected bytes sent (first %h), required none",
                     name, txq.size(), txq[0]);
            txq.delete();
        end
    endtask

    task automatic pulseStart();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        repeat (8) @(posedge clk);
        #1 rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1 rx_done = 1'b0;
    endtask

    task automatic expectTx(input string name, input logic [7:0] b, input int bound);
        logic [7:0] got;
        for (int c = 0; c < bound && txq.size() == 0; c++) @(posedge clk);
        tests++;
        if (txq.size() == 0) begin
            fails++;
            $display("[TB] FAIL %s: no command within %0d cycles, required %h",
                     name, bound, b);
        end else begin
            got = txq.pop_front();
            if (got !== b) begin
                fails++;
                $display("[TB] FAIL %s: command got %h required %h", name, got, b);
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        string name;
        name = $sformatf("step%0d", idx);
        case (v.kind)
            K_START:  pulseStart();
            K_TX:     expectTx({name, "_cmd"}, v.data, v.cycles);
            K_RX:     sendByte(v.data);
            K_WAIT:   repeat (v.cycles) @(posedge clk);
            K_QEMPTY: checkQueueEmpty(name);
            default:  ;
        endcase
        if (v.kind != K_QEMPTY) begin
            repeat (2) @(negedge clk);
            checkOutput(name, v.exp);
        end
    endtask

    initial begin
        // Normal initialisation, with one unlisted byte discarded in WAIT_BAT
        add(K_START, 8'h00, 0,   st(0, 1, 0, 0));
        add(K_TX,    8'hFF, 400, st(0, 1, 0, 0));
        add(K_RX,    8'hFA, 0,   st(0, 1, 0, 0));
        add(K_RX,    8'h55, 0,   st(0, 1, 0, 0));
        add(K_RX,    8'hAA, 0,   st(0, 1, 0, 0));
        addIdOk(0);
        add(K_TX,    8'hF4, 400, st(0, 1, 0, 0));
        add(K_RX,    8'hFA, 0,   st(1, 0, 0, 0));
        add(K_QEMPTY, 8'h00, 0,  st(0, 0, 0, 0));

        // Resend of F4: only F4 repeats, one retry counted
        add(K_START, 8'h00, 0,   st(0, 1, 0, 0));
        add(K_TX,    8'hFF, 400, st(0, 1, 0, 0));
        add(K_RX,    8'hFA, 0,   st(0, 1, 0, 0));
        add(K_RX,    8'hAA, 0,   st(0, 1, 0, 0));
        addIdOk(0);
        add(K_TX,    8'hF4, 400, st(0, 1, 0, 0));
        add(K_RX,    8'hFE, 0,   st(0, 1, 0, 1));
        add(K_TX,    8'hF4, 400, st(0, 1, 0, 1));
        add(K_RX,    8'hFA, 0,   st(1, 0, 0, 1));
        add(K_QEMPTY, 8'h00, 0,  st(0, 0, 0, 0));

        // BAT failure, then a bad ID, then success
        add(K_START, 8'h00, 0,   st(0, 1, 0, 0));
        add(K_TX,    8'hFF, 400, st(0, 1, 0, 0));
        add(K_RX,    8'hFA, 0,   st(0, 1, 0, 0));
        add(K_RX,    8'hFC, 0,   st(0, 1, 0, 1));
        add(K_TX,    8'hFF, 400, st(0, 1, 0, 1));
        add(K_RX,    8'hFA, 0,   st(0, 1, 0, 1));
        add(K_RX,    8'hAA, 0,   st(0, 1, 0, 1));
        add(K_RX,    8'h03, 0,   st(0, 1, 0, 2));
        add(K_TX,    8'hFF, 400, st(0, 1, 0, 2));
        add(K_RX,    8'hFA, 0,   st(0, 1, 0, 2));
        add(K_RX,    8'hAA, 0,   st(0, 1, 0, 2));
        addIdOk(2);
        add(K_TX,    8'hF4, 400, st(0, 1, 0, 2));
        add(K_RX,    8'hFA, 0,   st(1, 0, 0, 2));
        add(K_QEMPTY, 8'h00, 0,  st(0, 0, 0, 0));

        // Silent mouse: four FF attempts, then ERROR
        add(K_START, 8'h00, 0,   st(0, 1, 0, 0));
        add(K_TX,    8'hFF, 400, st(0, 1, 0, 0));
        add(K_TX,    8'hFF, 400, st(0, 1, 0, 1));
        add(K_TX,    8'hFF, 400, st(0, 1, 0, 2));
        add(K_TX,    8'hFF, 400, st(0, 1, 0, 3));
        add(K_WAIT,  8'h00, 200, st(0, 0, 1, 3));
        add(K_QEMPTY, 8'h00, 0,  st(0, 0, 0, 0));

        // Reset state
        repeat (3) @(negedge clk);
        tests++;
        if ({tx_start, tx_data, stream_en, init_busy, init_error, retry_cnt} !== 14'h0) begin
            fails++;
            $display("[TB] FAIL reset_state: got %b required %b",
                     {tx_start, tx_data, stream_en, init_busy, init_error, retry_cnt}, 14'h0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_after_reset", st(0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // Restart from ERROR clears init_error and retry_cnt
        pulseStart();
        repeat (2) @(negedge clk);
        checkOutput("error_restart", st(0, 1, 0, 0));
        expectTx("error_restart_cmd", 8'hFF, 400);
        sendByte(8'hFA);
        repeat (2) @(negedge clk);
        checkOutput("wait_bat", st(0, 1, 0, 0));

        // Start while busy must be ignored
        pulseStart();
        repeat (4) @(negedge clk);
        checkOutput("start_busy", st(0, 1, 0, 0));
        checkQueueEmpty("start_busy_notx");

        // Reset asserted in WAIT_BAT
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({tx_start, tx_data, stream_en, init_busy, init_error, retry_cnt} !== 14'h0) begin
            fails++;
            $display("[TB] FAIL mid_reset: got %b required %b",
                     {tx_start, tx_data, stream_en, init_busy, init_error, retry_cnt}, 14'h0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_after_mid_reset", st(0, 0, 0, 0));
        pulseStart();
        expectTx("restart_after_reset_cmd", 8'hFF, 400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
